spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Receive-side counterpart of the LIF neuron array: takes the per-neuron spike lines (the `spike*` outputs driven onto `uio_out[7:5]`) and decodes them back into firing-rate values. For each channel it counts spikes over a fixed window of clock cycles and snapshots the counts at window end. It then streams one count word per channel over a valid/ready interface to a readout path or host. Counting of the next window overlaps with streaming of the previous one.

## Interface
Parameters:
- `N_CH`, default 3: number of spike channels; minimum 1.
- `WINDOW`, default 256: window length in enabled clock cycles; minimum 2.
- `CNT_W`, default `$clog2(WINDOW+1)` (9): count word width. Derived; do not override.
- `CH_W`, default `$clog2(N_CH)`, with a minimum of 1 (2 at the default): channel index width. Derived.

Ports:
- `clk`, in, 1: the single clock; every register uses its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `en`, in, 1: when 1, the window counter and the spike accumulators advance; when 0, both hold.
- `spike_in`, in, `N_CH`: spike lines; bit i is channel i.
- `rate_data`, out, `CNT_W`: spike count for channel `rate_ch`.
- `rate_ch`, out, `CH_W`: channel index of the current word.
- `rate_valid`, out, 1: word available.
- `rate_ready`, in, 1: downstream accepts the word.
- `rate_last`, out, 1: current word is channel `N_CH-1`.
- `overrun`, out, 1: sticky flag; set when a window's counts were dropped.

## Operation
- Window counter `wcnt` runs 0..`WINDOW-1` and advances only when `en`=1. It wraps to 0 after `WINDOW-1`.
- Accumulator i increments on each enabled cycle in which a spike is detected on channel i.
  - Spike detection depends on configuration (see Configuration).
  - A count of `WINDOW` needs no saturation because `CNT_W` holds it.
- Window end is an enabled cycle with `wcnt==WINDOW-1`. On that cycle:
  - The accumulator values, including that cycle's spikes, are offered to the snapshot register.
  - All accumulators clear to 0.
- FSM states:
  - IDLE: no snapshot pending.
    - Window end loads the snapshot, sets the channel pointer to 0 and moves to EMIT.
  - EMIT: `rate_valid`=1, `rate_ch`=pointer, `rate_data`=snapshot[pointer].
    - A handshake (`rate_valid && rate_ready`) advances the pointer.
    - A handshake with `rate_last`=1 returns to IDLE.
- Window end while in EMIT, with no last handshake on the same cycle:
  - The new counts are discarded.
  - The snapshot is unchanged.
  - `overrun` is set.
- Window end on the same cycle as the last handshake:
  - The new counts are loaded.
  - The pointer goes to 0 and the FSM stays in EMIT.
  - `overrun` is not set.
- `overrun` is cleared only by `rst`.
- Outputs are stable while `rate_valid`=1 and `rate_ready`=0.
- `en`=0 does not stall emission.

## Timing
- Values after reset:
  - `rate_valid`=0, `rate_last`=0, `overrun`=0.
  - `rate_ch`=0, `rate_data`=0.
  - `wcnt`=0, all accumulators 0, edge-history register 0, FSM in IDLE.
- `rst` asserted mid-window or mid-emission:
  - Discards the partial window and any pending snapshot.
  - On the next cycle the block matches the reset state above.
- Latency: `rate_valid` rises on the cycle after the window-end cycle.
- Throughput: one word per cycle while `rate_ready`=1.
- All outputs are registered; there is no combinational path from `rate_ready` to any output.
- The first window after reset or after `rst` release covers `WINDOW` enabled cycles starting with the first cycle where `rst`=0.

## Configuration
- Macro `SPIKE_DEC_EDGE_DETECT_EN`.
- Defined:
  - A spike is a rising edge on `spike_in[i]`, i.e. current sample 1 and previous sample 0.
  - The previous-sample register updates every cycle, regardless of `en`.
  - The maximum count is `ceil(WINDOW/2)`.
- Undefined:
  - Every enabled cycle with `spike_in[i]`=1 counts as one spike.
  - There is no edge-history register.

## Structure
- Package `spike_dec_pkg` holds:
  - Default `N_CH`/`WINDOW` constants.
  - FSM state typedef (IDLE, EMIT).
- Sub-module `spike_counter` is instantiated once per channel. It contains:
  - Optional edge detect.
  - The accumulator, with inputs `inc_en`, `clear`, `spike`.
  - Output `count`.
- The top level holds:
  - The window counter.
  - The snapshot array.
  - The FSM.
  - The overrun flag.

## Test plan
Use `WINDOW`=8 and `N_CH`=3, with `en`=1 and `rate_ready`=1 unless stated.
- `spike_in`=3'b001 held for 8 cycles, macro undefined -> three words, in order: (ch0, 8), (ch1, 0), (ch2, 0, `rate_last`=1).
- Same stimulus, macro defined -> ch0=1, ch1=0, ch2=0.
- ch1 toggling every cycle (1,0,1,0,...) -> ch1=4 in both configurations; `rate_valid` rises on the cycle after the 8th cycle.
- `rate_ready`=0 for 20 cycles, then 1 -> `overrun`=1 after the second window end, and the words emitted are the first window's counts.
- Stall `rate_ready` so that the ch2 handshake falls on a window-end cycle -> `overrun` stays 0, and the next cycle shows (ch0, new count).
- ch0 held high for 5 cycles, then `rst` for 1 cycle, then 8 cycles with `spike_in`=3'b100 -> no words before the rst; after the rst, words are ch0=0, ch2=8 (macro undefined).

Source files
------------

// File: rtl/spike_dec_pkg.sv
// -----------------------------------------------------------------------------
// spike_dec_pkg
// Shared definitions for the spike rate decoder:
//   - default channel count and window length
//   - FSM state type for the readout sequencer (IDLE, EMIT)
// -----------------------------------------------------------------------------
package spike_dec_pkg;

    localparam int N_CH_DEF   = 3;
    localparam int WINDOW_DEF = 256;

    typedef enum logic {
        IDLE = 1'b0,   // no snapshot pending
        EMIT = 1'b1    // streaming snapshot words, one channel per handshake
    } dec_state_t;

endpackage

// File: rtl/spike_counter.sv
// -----------------------------------------------------------------------------
// spike_counter
// Per-channel spike accumulator for the spike rate decoder.
//
// Configuration macro: SPIKE_DEC_EDGE_DETECT_EN
//   defined   : a spike is a rising edge (current 1, previous 0); the
//               previous-sample register updates every cycle, independent
//               of inc_en.
//   undefined : every enabled cycle with spike=1 counts; no history register.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   inc_en in   count this cycle's spike (window advancing)
//   clear  in   window end: accumulator restarts at 0 next cycle
//   spike  in   raw spike line for this channel
//   count  out  accumulator value including this cycle's spike, so the
//               window-end snapshot sees the final cycle's contribution
// -----------------------------------------------------------------------------
module spike_counter #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic             clear,
    input  logic             spike,
    output logic [CNT_W-1:0] count
);

    logic             hit;
    logic [CNT_W-1:0] acc;

`ifdef SPIKE_DEC_EDGE_DETECT_EN
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= spike;
        end
    end

    assign hit = spike & ~prev;
`else
    assign hit = spike;
`endif

    // When inc_en is low this equals acc, so the register update below
    // holds the value without a separate enable branch.
    assign count = acc + {{(CNT_W-1){1'b0}}, inc_en & hit};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else begin
            acc <= count;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
// Counts spikes per channel over a window of WINDOW enabled cycles, snapshots
// the counts at window end and streams one word per channel over a
// valid/ready port while the next window is being counted.
//
// Configuration macro: SPIKE_DEC_EDGE_DETECT_EN (edge vs level spike counting,
// implemented inside spike_counter).
//
// Handshake: a word transfers on every rising clk edge where rate_valid and
// rate_ready are both 1. While rate_valid=1 and rate_ready=0 all rate_*
// outputs hold. All outputs are registered; rate_ready only affects the
// next-state logic.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   advance window counter and accumulators
//   spike_in   in   [N_CH] spike lines, bit i = channel i
//   rate_data  out  [CNT_W] spike count of channel rate_ch
//   rate_ch    out  [CH_W] channel index of current word
//   rate_valid out  word available
//   rate_ready in   downstream accepts word
//   rate_last  out  current word is channel N_CH-1
//   overrun    out  sticky: a window's counts were dropped (cleared by rst)
// -----------------------------------------------------------------------------
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int WINDOW = WINDOW_DEF,
    parameter int CNT_W  = $clog2(WINDOW + 1),
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_CH-1:0]  spike_in,
    output logic [CNT_W-1:0] rate_data,
    output logic [CH_W-1:0]  rate_ch,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             rate_last,
    output logic             overrun
);

    localparam int WCNT_W = $clog2(WINDOW);

    logic [WCNT_W-1:0] wcnt;
    logic              win_end;
    logic [CNT_W-1:0]  counts [N_CH];
    logic [CNT_W-1:0]  snap   [N_CH];
    dec_state_t        state;
    logic              handshake;
    logic              last_hs;
    logic              load;
    logic [CH_W-1:0]   next_ch;

    // ---------------- window counter ----------------
    assign win_end = en && (wcnt == WCNT_W'(WINDOW - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (en) begin
            if (wcnt == WCNT_W'(WINDOW - 1)) begin
                wcnt <= '0;
            end else begin
                wcnt <= wcnt + WCNT_W'(1);
            end
        end
    end

    // ---------------- per-channel accumulators ----------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        spike_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc_en (en),
            .clear  (win_end),
            .spike  (spike_in[i]),
            .count  (counts[i])
        );
    end

    // ---------------- readout FSM ----------------
    assign handshake = rate_valid && rate_ready;
    assign last_hs   = handshake && rate_last;
    // A window end is accepted when nothing is pending, or when the final
    // word of the pending snapshot leaves on the same edge.
    assign load      = win_end && ((state == IDLE) || last_hs);
    assign next_ch   = rate_ch + CH_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rate_valid <= 1'b0;
            rate_last  <= 1'b0;
            rate_ch    <= '0;
            rate_data  <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                snap[i] <= '0;
            end
        end else begin
            if (load) begin
                for (int i = 0; i < N_CH; i++) begin
                    snap[i] <= counts[i];
                end
                state      <= EMIT;
                rate_valid <= 1'b1;
                rate_ch    <= '0;
                rate_data  <= counts[0];
                rate_last  <= (N_CH == 1);
            end else if (last_hs) begin
                state      <= IDLE;
                rate_valid <= 1'b0;
                rate_last  <= 1'b0;
            end else if (handshake) begin
                rate_ch    <= next_ch;
                rate_data  <= snap[next_ch];
                rate_last  <= (next_ch == CH_W'(N_CH - 1));
            end

            // Window end with a snapshot still being streamed: counts dropped.
            if (win_end && (state == EMIT) && !last_hs) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
// Directed bench for spike_rate_decoder with WINDOW=8, N_CH=3.
// Expected counts depend on SPIKE_DEC_EDGE_DETECT_EN, selected at compile time.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

    localparam int N_CH   = 3;
    localparam int WINDOW = 8;
    localparam int CNT_W  = 4;
    localparam int CH_W   = 2;
    localparam int W      = CH_W + CNT_W + 1;

`ifdef SPIKE_DEC_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             en;
    logic [N_CH-1:0]  spike_in;
    logic [CNT_W-1:0] rate_data;
    logic [CH_W-1:0]  rate_ch;
    logic             rate_valid;
    logic             rate_ready;
    logic             rate_last;
    logic             overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];

    spike_rate_decoder #(
        .N_CH   (N_CH),
        .WINDOW (WINDOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .rate_data  (rate_data),
        .rate_ch    (rate_ch),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .rate_last  (rate_last),
        .overrun    (overrun)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        en         = 1'b1;
        spike_in   = '0;
        rate_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push_word(input int ch, input int data, input bit last);
        exp_q.push_back({CH_W'(ch), CNT_W'(data), last});
    endtask

    task automatic push_window(input int c0, input int c1, input int c2);
        push_word(0, c0, 1'b0);
        push_word(1, c1, 1'b0);
        push_word(2, c2, 1'b1);
    endtask

    // Pops expected words and compares them to each accepted word.
    task automatic drain(input string name);
        logic [W-1:0] e;
        int           waited;
        rate_ready = 1'b1;
        while (exp_q.size() > 0) begin
            waited = 0;
            while (!rate_valid && waited < 40) begin
                step();
                waited++;
            end
            if (!rate_valid) begin
                check({name, " valid_timeout"}, 0, 1);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                check({name, " word"}, int'({rate_ch, rate_data, rate_last}), int'(e));
                step();
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string          name;
        logic [N_CH-1:0] spk_even;  // pattern on window cycles 0,2,4,6
        logic [N_CH-1:0] spk_odd;   // pattern on window cycles 1,3,5,7
        int             lvl0, lvl1, lvl2;
        int             edg0, edg1, edg2;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"ch0_hold",   3'b001, 3'b001, 8, 0, 0, 1, 0, 0};
        vecs[1] = '{"ch1_toggle", 3'b010, 3'b000, 0, 4, 0, 0, 4, 0};
        vecs[2] = '{"mixed",      3'b111, 3'b110, 4, 8, 8, 4, 1, 1};
        vecs[3] = '{"silent",     3'b000, 3'b000, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{"antiphase",  3'b100, 3'b011, 4, 4, 4, 4, 4, 4};

        rst        = 1'b1;
        en         = 1'b1;
        spike_in   = '0;
        rate_ready = 1'b1;

        // ---------- reset state ----------
        do_reset();
        check("reset valid",   int'(rate_valid), 0);
        check("reset last",    int'(rate_last),  0);
        check("reset overrun", int'(overrun),    0);
        check("reset ch",      int'(rate_ch),    0);
        check("reset data",    int'(rate_data),  0);

        // ---------- table-driven windows ----------
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int k = 0; k < WINDOW; k++) begin
                spike_in = (k % 2 == 0) ? vecs[v].spk_even : vecs[v].spk_odd;
                step();
                if (k == WINDOW - 2) check({vecs[v].name, " valid_early"}, int'(rate_valid), 0);
            end
            spike_in = '0;
            check({vecs[v].name, " valid_latency"}, int'(rate_valid), 1);
            if (EDGE) push_window(vecs[v].edg0, vecs[v].edg1, vecs[v].edg2);
            else      push_window(vecs[v].lvl0, vecs[v].lvl1, vecs[v].lvl2);
            drain(vecs[v].name);
            check({vecs[v].name, " overrun"}, int'(overrun), 0);
        end

        // ---------- overrun: ready low for 20 cycles ----------
        do_reset();
        rate_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            spike_in = (k <= 8) ? 3'b001 : 3'b010;
            step();
            if (k == 12) begin
                check("ovr stall ch",   int'(rate_ch),   0);
                check("ovr stall data", int'(rate_data), EDGE ? 1 : 8);
            end
            if (k == 15) check("ovr before_2nd_end", int'(overrun), 0);
            if (k == 16) check("ovr at_2nd_end",     int'(overrun), 1);
        end
        spike_in = '0;
        check("ovr stall valid", int'(rate_valid), 1);
        push_window(EDGE ? 1 : 8, 0, 0);      // first window survives
        push_window(0, EDGE ? 0 : 4, 0);      // third window (cycles 17..24)
        drain("ovr");
        check("ovr sticky", int'(overrun), 1);

        // ---------- last handshake on a window-end cycle ----------
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            spike_in = 3'b001;
            step();
        end
        spike_in   = 3'b100;
        rate_ready = 1'b0;
        for (int k = 9; k <= 13; k++) step();
        check("coin w0 ch",   int'(rate_ch),   0);
        check("coin w0 data", int'(rate_data), EDGE ? 1 : 8);
        rate_ready = 1'b1;
        step();                                   // edge 14: ch0 accepted
        check("coin w1 ch",   int'(rate_ch),   1);
        step();                                   // edge 15: ch1 accepted
        check("coin w2 ch",   int'(rate_ch),   2);
        check("coin w2 last", int'(rate_last), 1);
        step();                                   // edge 16: ch2 accepted + window end
        spike_in = '0;
        check("coin overrun", int'(overrun),    0);
        check("coin valid",   int'(rate_valid), 1);
        push_window(0, 0, EDGE ? 1 : 8);
        drain("coin next");
        check("coin overrun_end", int'(overrun), 0);

        // ---------- reset mid-window ----------
        do_reset();
        for (int k = 0; k < 5; k++) begin
            spike_in = 3'b001;
            step();
            check("rstmid no_word", int'(rate_valid), 0);
        end
        spike_in = '0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid valid", int'(rate_valid), 0);
        check("rstmid data",  int'(rate_data),  0);
        for (int k = 0; k < WINDOW; k++) begin
            spike_in = 3'b100;
            step();
        end
        spike_in = '0;
        check("rstmid latency", int'(rate_valid), 1);
        push_window(0, 0, EDGE ? 1 : 8);
        drain("rstmid");

        // ---------- reset mid-emission ----------
        do_reset();
        for (int k = 0; k < WINDOW; k++) begin
            spike_in = 3'b010;
            step();
        end
        spike_in = '0;
        step();                                   // ch0 accepted, ch1 showing
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstemit valid", int'(rate_valid), 0);
        check("rstemit ch",    int'(rate_ch),    0);
        check("rstemit data",  int'(rate_data),  0);
        check("rstemit last",  int'(rate_last),  0);
        for (int k = 0; k < WINDOW - 1; k++) step();
        check("rstemit no_word", int'(rate_valid), 0);
        step();
        push_window(0, 0, 0);
        drain("rstemit");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
